// File: rtl/alu_control_regfile.sv
// Single-cycle RV32I integer slice: decode, 32x32 register file and ALU.
// Reads and ALU are combinational; rd writeback and the sticky halt flag update on the rising edge.
module alu_control_regfile (
   input  logic        clk,
   input  logic        rst_b,
   input  logic [31:0] inst,
   input  logic        inst_valid,
   output logic [31:0] rs1_data,
   output logic [31:0] rs2_data,
   output logic [31:0] alu_result,
   output logic        rd_we,
   output logic        halted
);

   localparam logic [6:0] OPC_OP     = 7'h33;
   localparam logic [6:0] OPC_OP_IMM = 7'h13;
   localparam logic [6:0] OPC_SYSTEM = 7'h73;
   localparam logic [6:0] F7_BASE    = 7'h00;
   localparam logic [6:0] F7_ALT     = 7'h20;

   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_SLL,
      ALU_SLT,
      ALU_SLTU,
      ALU_XOR,
      ALU_SRL,
      ALU_SRA,
      ALU_OR,
      ALU_AND,
      ALU_ZERO
   } alu_op_e;

   logic [6:0]  opcode;
   logic [4:0]  rd;
   logic [2:0]  funct3;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [6:0]  funct7;
   logic [31:0] imm_i;

   logic        is_op;
   logic        is_op_imm;
   logic        is_system;
   logic        funct7_ok;

   alu_op_e     alu_op;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [4:0]  shamt;
   logic [31:0] alu_out;

   logic [31:0] regs_q [0:31];
   logic [31:0] regs_d [0:31];
   logic        halted_q;
   logic        halted_d;

   // ------------------------------------------------------------------
   // Field decode
   // ------------------------------------------------------------------
   always_comb begin
      opcode    = inst[6:0];
      rd        = inst[11:7];
      funct3    = inst[14:12];
      rs1       = inst[19:15];
      rs2       = inst[24:20];
      funct7    = inst[31:25];
      imm_i     = {{20{inst[31]}}, inst[31:20]};
      is_op     = (opcode == OPC_OP);
      is_op_imm = (opcode == OPC_OP_IMM);
      is_system = (opcode == OPC_SYSTEM);
      funct7_ok = (funct7 == F7_BASE) || (funct7 == F7_ALT);
   end

   // ------------------------------------------------------------------
   // Register file read (x0 hard-wired to zero, no bypass)
   // ------------------------------------------------------------------
   always_comb begin
      rs1_data = (rs1 == 5'd0) ? 32'd0 : regs_q[rs1];
      rs2_data = (rs2 == 5'd0) ? 32'd0 : regs_q[rs2];
   end

   // ------------------------------------------------------------------
   // ALU operation select; OP-IMM has no subtract, so inst[30] only
   // matters there for the right-shift variant.
   // ------------------------------------------------------------------
   always_comb begin
      alu_op = ALU_ZERO;
      if (is_op || is_op_imm) begin
         case (funct3)
            3'd0: alu_op = (is_op && inst[30]) ? ALU_SUB : ALU_ADD;
            3'd1: alu_op = ALU_SLL;
            3'd2: alu_op = ALU_SLT;
            3'd3: alu_op = ALU_SLTU;
            3'd4: alu_op = ALU_XOR;
            3'd5: alu_op = inst[30] ? ALU_SRA : ALU_SRL;
            3'd6: alu_op = ALU_OR;
            3'd7: alu_op = ALU_AND;
            default: alu_op = ALU_ZERO;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Operand mux and ALU
   // ------------------------------------------------------------------
   always_comb begin
      op_a  = rs1_data;
      op_b  = is_op ? rs2_data : imm_i;
      shamt = op_b[4:0];
   end

   always_comb begin
      alu_out = 32'd0;
      case (alu_op)
         ALU_ADD:  alu_out = op_a + op_b;
         ALU_SUB:  alu_out = op_a - op_b;
         ALU_SLL:  alu_out = op_a << shamt;
         ALU_SLT:  alu_out = ($signed(op_a) < $signed(op_b)) ? 32'd1 : 32'd0;
         ALU_SLTU: alu_out = (op_a < op_b) ? 32'd1 : 32'd0;
         ALU_XOR:  alu_out = op_a ^ op_b;
         ALU_SRL:  alu_out = op_a >> shamt;
         ALU_SRA:  alu_out = $unsigned($signed(op_a) >>> shamt);
         ALU_OR:   alu_out = op_a | op_b;
         ALU_AND:  alu_out = op_a & op_b;
         default:  alu_out = 32'd0;
      endcase
   end

   assign alu_result = alu_out;

   // ------------------------------------------------------------------
   // Write enable and next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      rd_we = inst_valid && !halted_q && (rd != 5'd0) &&
              ((is_op && funct7_ok) || is_op_imm);
   end

   always_comb begin
      for (int i = 0; i < 32; i++) begin
         regs_d[i] = regs_q[i];
      end
      if (rd_we) begin
         regs_d[rd] = alu_out;
      end
      regs_d[0] = 32'd0;
   end

   always_comb begin
      halted_d = halted_q;
      if (inst_valid && !halted_q && is_system) begin
         halted_d = 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // State registers; reset wins over any concurrent write or halt
   // ------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < 32; gi++) begin : g_reg
         always_ff @(posedge clk) begin
            if (!rst_b) begin
               regs_q[gi] <= 32'd0;
            end else begin
               regs_q[gi] <= regs_d[gi];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         halted_q <= 1'b0;
      end else begin
         halted_q <= halted_d;
      end
   end

   assign halted = halted_q;

endmodule

// File: tb/tb_alu_control_regfile.sv
// Bench for alu_control_regfile: directed vector table, hand-written reset sequences,
// then randomized instructions checked against an architectural reference model.
module tb_alu_control_regfile;

   logic        clk = 1'b0;
   logic        rst_b;
   logic [31:0] inst;
   logic        inst_valid;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [31:0] alu_result;
   logic        rd_we;
   logic        halted;

   always #5 clk = ~clk;

   alu_control_regfile dut (
      .clk        (clk),
      .rst_b      (rst_b),
      .inst       (inst),
      .inst_valid (inst_valid),
      .rs1_data   (rs1_data),
      .rs2_data   (rs2_data),
      .alu_result (alu_result),
      .rd_we      (rd_we),
      .halted     (halted)
   );

   int compared   = 0;
   int mismatched = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2,
                                         input logic [4:0] r1, input logic [2:0] f3,
                                         input logic [4:0] rdx);
      return {f7, r2, r1, f3, rdx, 7'h33};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] r1,
                                         input logic [2:0] f3, input logic [4:0] rdx,
                                         input logic [6:0] op);
      return {imm, r1, f3, rdx, op};
   endfunction

   // ------------------------------------------------------------------
   // Reference model: architectural register array and halt flag
   // ------------------------------------------------------------------
   logic [31:0] m_regs [32];
   logic        m_halt;

   function automatic logic [31:0] m_read(input logic [4:0] r);
      return (r == 5'd0) ? 32'd0 : m_regs[r];
   endfunction

   // Expected ALU result / write enable from the instruction semantics.
   function automatic void m_eval(input logic [31:0] w, input logic v,
                                  output logic [31:0] res, output logic we,
                                  output logic res_defined);
      logic [31:0] a, b;
      logic        legal;
      int          sh;
      res = 32'd0;
      we = 1'b0;
      res_defined = 1'b1;
      a = m_read(w[19:15]);
      if (w[6:0] == 7'h33) begin
         b = m_read(w[24:20]);
         legal = (w[31:25] == 7'h00) || (w[31:25] == 7'h20);
      end else if (w[6:0] == 7'h13) begin
         b = {{20{w[31]}}, w[31:20]};
         legal = 1'b1;
      end else begin
         return;
      end
      sh = int'(b % 32);
      case (w[14:12])
         3'd0: res = (w[6:0] == 7'h33 && w[31:25] == 7'h20) ? a - b : a + b;
         3'd1: res = a << sh;
         3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd3: res = (a < b) ? 32'd1 : 32'd0;
         3'd4: res = a ^ b;
         3'd5: res = w[30] ? 32'($signed(a) >>> sh) : a >> sh;
         3'd6: res = a | b;
         default: res = a & b;
      endcase
      res_defined = legal;
      we = v && !m_halt && legal && (w[11:7] != 5'd0);
   endfunction

   // ------------------------------------------------------------------
   // Directed vector table
   // ------------------------------------------------------------------
   typedef struct {
      logic [31:0] inst;
      logic        valid;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] alu;
      logic        chk_alu;
      logic        we;
      logic        halt_after;
   } vec_t;

   vec_t vecs[$];

   function automatic void add_vec(input logic [31:0] w, input logic v, input logic [31:0] r1,
                                   input logic [31:0] r2, input logic [31:0] al,
                                   input logic ca, input logic we, input logic h);
      vec_t t;
      t.inst = w; t.valid = v; t.rs1 = r1; t.rs2 = r2; t.alu = al;
      t.chk_alu = ca; t.we = we; t.halt_after = h;
      vecs.push_back(t);
   endfunction

   initial begin
      logic [31:0] e_res;
      logic        e_we;
      logic        e_def;
      logic [31:0] w;
      logic        v;

      // rows: inst, valid, rs1_data, rs2_data, alu_result, check alu, rd_we, halted after edge
      add_vec(32'h00500093,             1, 0, 0, 32'd5, 1, 1, 0);                          // addi x1,x0,5
      add_vec(32'hFFD00113,             1, 0, 0, 32'hFFFFFFFD, 1, 1, 0);                   // addi x2,x0,-3
      add_vec(enc_r(7'h20, 2, 1, 0, 3), 1, 5, 32'hFFFFFFFD, 32'd8, 1, 1, 0);               // sub x3,x1,x2
      add_vec(enc_r(7'h00, 1, 2, 2, 4), 1, 32'hFFFFFFFD, 5, 32'd1, 1, 1, 0);               // slt x4,x2,x1
      add_vec(enc_r(7'h00, 1, 2, 3, 5), 1, 32'hFFFFFFFD, 5, 32'd0, 1, 1, 0);               // sltu x5,x2,x1
      add_vec(enc_i(12'h401, 2, 5, 6, 7'h13), 1, 32'hFFFFFFFD, 5, 32'hFFFFFFFE, 1, 1, 0);  // srai x6,x2,1
      add_vec(enc_i(12'h001, 2, 5, 7, 7'h13), 1, 32'hFFFFFFFD, 5, 32'h7FFFFFFE, 1, 1, 0);  // srli x7,x2,1
      add_vec(enc_i(12'h007, 0, 0, 0, 7'h13), 1, 0, 32'h7FFFFFFE, 32'd7, 1, 0, 0);         // addi x0,x0,7
      add_vec(enc_i(12'h001, 1, 0, 1, 7'h13), 1, 5, 5, 32'd6, 1, 1, 0);                    // addi x1,x1,1 (old value read)
      add_vec(enc_r(7'h00, 0, 1, 0, 8), 1, 6, 0, 32'd6, 1, 1, 0);                          // add x8,x1,x0 (new value)
      add_vec(enc_i(12'h001, 0, 0, 1, 7'h13), 0, 0, 6, 32'd1, 1, 0, 0);                    // invalid addi x1,x0,1
      add_vec(enc_r(7'h00, 0, 1, 0, 9), 1, 6, 0, 32'd6, 1, 1, 0);                          // add x9,x1,x0
      add_vec(enc_i(12'h000, 1, 2, 10, 7'h03), 1, 6, 0, 32'd0, 1, 0, 0);                   // lw: no write
      add_vec(enc_r(7'h00, 0, 10, 0, 11), 1, 0, 0, 32'd0, 1, 1, 0);                        // add x11,x10,x0
      add_vec(enc_i(12'h400, 1, 0, 15, 7'h13), 1, 6, 0, 32'd1030, 1, 1, 0);                // addi with bit30 set: no subi
      add_vec(enc_r(7'h01, 1, 1, 0, 13), 1, 6, 6, 32'd0, 0, 0, 0);                         // undefined funct7
      add_vec(enc_r(7'h00, 0, 13, 0, 12), 1, 0, 0, 32'd0, 1, 1, 0);                        // x13 stayed 0
      add_vec(32'h00000073,             1, 0, 0, 32'd0, 1, 0, 1);                          // ecall
      add_vec(32'h00900093,             1, 0, 6, 32'd9, 1, 0, 1);                          // addi x1,x0,9 ignored
      add_vec(enc_r(7'h00, 0, 1, 0, 14), 1, 6, 0, 32'd6, 1, 0, 1);                         // x1 unchanged
      add_vec(32'h00100073,             1, 0, 6, 32'd0, 1, 0, 1);                          // ebreak while halted

      // ---------------- reset state ----------------
      rst_b = 1'b0;
      inst_valid = 1'b0;
      inst = enc_r(7'h00, 31, 1, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_b = 1'b1;
      #1;
      check("reset_halted", {31'd0, halted}, 32'd0);
      check("reset_rs1_x1", rs1_data, 32'd0);
      check("reset_rs2_x31", rs2_data, 32'd0);
      check("reset_rd_we", {31'd0, rd_we}, 32'd0);

      // ---------------- table ----------------
      foreach (vecs[i]) begin
         @(negedge clk);
         inst = vecs[i].inst;
         inst_valid = vecs[i].valid;
         #1;
         $display("vec %0d inst=%08h v=%0d rs1=%08h rs2=%08h alu=%08h we=%0d", i, inst,
                  inst_valid, rs1_data, rs2_data, alu_result, rd_we);
         check($sformatf("vec%0d_rs1", i), rs1_data, vecs[i].rs1);
         check($sformatf("vec%0d_rs2", i), rs2_data, vecs[i].rs2);
         if (vecs[i].chk_alu) check($sformatf("vec%0d_alu", i), alu_result, vecs[i].alu);
         check($sformatf("vec%0d_we", i), {31'd0, rd_we}, {31'd0, vecs[i].we});
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_halt", i), {31'd0, halted}, {31'd0, vecs[i].halt_after});
      end

      // ---------------- reset while halted, with a simultaneous write ----------------
      @(negedge clk);
      rst_b = 1'b0;
      inst = 32'h00500093;
      inst_valid = 1'b1;
      @(posedge clk);
      #1;
      $display("seq reset-while-halted halted=%0d", halted);
      check("rst_clears_halt", {31'd0, halted}, 32'd0);
      @(negedge clk);
      rst_b = 1'b1;
      inst = enc_r(7'h00, 2, 1, 0, 0);
      inst_valid = 1'b0;
      #1;
      $display("seq post-reset read rs1=%08h rs2=%08h", rs1_data, rs2_data);
      check("rst_over_write_x1", rs1_data, 32'd0);
      check("rst_clears_x2", rs2_data, 32'd0);

      // ---------------- resume after reset ----------------
      inst = 32'h00500093;
      inst_valid = 1'b1;
      #1;
      check("resume_we", {31'd0, rd_we}, 32'd1);
      @(negedge clk);
      inst = enc_r(7'h00, 0, 1, 0, 0);
      inst_valid = 1'b0;
      #1;
      $display("seq resume x1=%08h", rs1_data);
      check("resume_x1", rs1_data, 32'd5);

      // ---------------- randomized against the reference model ----------------
      @(negedge clk);
      rst_b = 1'b0;
      @(posedge clk);
      for (int r = 0; r < 32; r++) m_regs[r] = 32'd0;
      m_halt = 1'b0;
      for (int n = 0; n < 400; n++) begin
         int k;
         logic [4:0] a1, a2, ad;
         logic [2:0] f3;
         logic [11:0] imm;
         @(negedge clk);
         k  = $urandom_range(0, 99);
         a1 = 5'($urandom_range(0, 7));
         a2 = 5'($urandom_range(0, 7));
         ad = 5'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) begin
            a1 = 5'($urandom);
            a2 = 5'($urandom);
            ad = 5'($urandom);
         end
         f3 = 3'($urandom);
         if (k < 40) begin
            w = enc_r(((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                      a2, a1, f3, ad);
         end else if (k < 82) begin
            imm = 12'($urandom);
            if (f3 == 1) imm[11:5] = 7'h00;
            if (f3 == 5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            w = enc_i(imm, a1, f3, ad, 7'h13);
         end else if (k < 89) begin
            w = enc_r(7'($urandom_range(1, 31)), a2, a1, f3, ad);
         end else if (k < 98) begin
            w = {25'($urandom), 7'h03};
            if ($urandom_range(0, 1) == 1) w[6:0] = 7'h37;
         end else begin
            w = {25'($urandom), 7'h73};
         end
         v = ($urandom_range(0, 9) != 0);
         rst_b = ($urandom_range(0, 39) != 0);
         inst = w;
         inst_valid = v;
         #1;
         m_eval(w, v, e_res, e_we, e_def);
         $display("rnd %0d inst=%08h v=%0d rst_b=%0d alu=%08h we=%0d", n, w, v, rst_b,
                  alu_result, rd_we);
         check("rnd_rs1", rs1_data, m_read(w[19:15]));
         check("rnd_rs2", rs2_data, m_read(w[24:20]));
         if (e_def) check("rnd_alu", alu_result, e_res);
         check("rnd_we", {31'd0, rd_we}, {31'd0, e_we});
         @(posedge clk);
         if (!rst_b) begin
            for (int r = 0; r < 32; r++) m_regs[r] = 32'd0;
            m_halt = 1'b0;
         end else if (v && !m_halt) begin
            if (e_we) m_regs[w[11:7]] = e_res;
            if (w[6:0] == 7'h73) m_halt = 1'b1;
         end
         #1;
         check("rnd_halt", {31'd0, halted}, {31'd0, m_halt});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
